// File: rtl/vld_rdy_fifo.sv
// ----------------------------------------------------------------------------
// vld_rdy_fifo
//   Synchronous data FIFO with a valid/ready handshake on both sides. It sits
//   behind a vld_rdy pipeline stage, absorbs backpressure bursts and feeds the
//   next consumer (execute / bus-issue stage). rdy_o is derived from
//   registered pointers only, so there is no combinational path from rdy_i
//   to rdy_o.
//
//   Optional feature macro: FIFO_BYPASS_EN
//     undefined (default) : a pushed word appears on vld_o/data_o one cycle
//                           after the push edge.
//     defined             : when the FIFO is empty, vld_i/data_i fall through
//                           combinationally to vld_o/data_o. If the consumer
//                           is ready, the word is handed over in the same
//                           cycle and is never stored.
//
// Parameters
//   DW     payload width in bits
//   DEPTH  number of entries (power of two, >= 2)
//   AW     pointer index width, derived from DEPTH
//
// Ports
//   clk      in   1     clock, all state on posedge
//   rst_n    in   1     asynchronous active-low reset
//   vld_i    in   1     upstream valid
//   rdy_o    out  1     upstream ready (FIFO not full)
//   data_i   in   DW    upstream payload
//   vld_o    out  1     downstream valid (FIFO not empty, or bypass)
//   rdy_i    in   1     downstream ready
//   data_o   out  DW    downstream payload (head entry, or bypass)
//   count_o  out  AW+1  occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module vld_rdy_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_i,
    output logic          rdy_o,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    input  logic          rdy_i,
    output logic [DW-1:0] data_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [DW-1:0] mem_r [DEPTH];

    logic          empty_s;
    logic          full_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [DW-1:0] head_s;

    // Status flags derived purely from the registered pointer pair.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        head_s  = mem_r[rd_ptr_r[AW-1:0]];
        count_o = wr_ptr_r - rd_ptr_r;
        rdy_o   = ~full_s;
    end

`ifdef FIFO_BYPASS_EN
    // Empty FIFO: present the upstream word directly; a same-cycle handover
    // consumes it without touching storage.
    always_comb begin
        bypass_s = 1'b0;
        vld_o    = 1'b0;
        data_o   = '0;
        if (empty_s) begin
            bypass_s = vld_i & rdy_i;
            vld_o    = vld_i;
            data_o   = data_i;
        end else begin
            bypass_s = 1'b0;
            vld_o    = 1'b1;
            data_o   = head_s;
        end
    end
`else
    // Default output path: head entry of registered storage.
    always_comb begin
        bypass_s = 1'b0;
        vld_o    = ~empty_s;
        data_o   = head_s;
    end
`endif

    // Handshake qualification. A full FIFO blocks the push even when a pop
    // frees a slot in the same cycle; the slot is offered next cycle.
    always_comb begin
        push_s = vld_i & ~full_s & ~bypass_s;
        pop_s  = rdy_i & ~empty_s;
    end

    // Pointer registers: advance independently on push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array: cleared on reset so data_o reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_i;
        end
    end

endmodule
